ptos_lane_arbiter: RTL and testbench
====================================

PTOS_LANE_ARBITER -- requirements
Module: ptos_lane_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of byte requesters sharing the lane.
REQ-002 SHALL have parameter SYNC_CNT, default 4, comma symbols sent after reset before data.
REQ-003 SHALL have parameter MAX_PKT, default 16, maximum payload bytes per grant.
REQ-004 SHALL have parameter COMMA, default 8'hBC, idle/comma symbol.
REQ-005 SHALL have port `clk`, input, 1: the single clock, equal to the byte clock of the parallel-to-serial converter; all logic on posedge.
REQ-006 SHALL have port `reset`, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port `req_data`, input, 8*NREQ: byte from requester i on bits [8i+7:8i].
REQ-008 SHALL have port `req_valid`, input, NREQ: requester i presents a byte.
REQ-009 SHALL have port `req_eop`, input, NREQ: the presented byte is the last of its packet.
REQ-010 SHALL have port `req_ready`, output, NREQ: the byte from requester i is accepted this cycle.
REQ-011 SHALL have port `pause`, input, 1: downstream flow-control hold.
REQ-012 SHALL have port `out_data`, output, 8: byte to the converter's `in`.
REQ-013 SHALL have port `out_valid`, output, 1: drives the converter's `in_valid`.
REQ-014 SHALL have port `grant_id`, output, clog2(NREQ): current owner of the lane.
REQ-015 SHALL have ports `sync_done` (1) and `trunc` (1), outputs: link synced; one-cycle pulse on forced release.

Function
REQ-016 SHALL implement an FSM with states SYNC, IDLE and DATA.
REQ-017 SYNC SHALL drive out_data=COMMA and out_valid=0 for exactly SYNC_CNT cycles, then enter IDLE and set sync_done=1.
REQ-018 In IDLE, with no req_valid, the block SHALL drive COMMA with out_valid=0 on the next cycle.
REQ-019 In IDLE, when any req_valid=1 and pause=0, the block SHALL grant round-robin starting at (last_grant+1) mod NREQ.
REQ-020 On a grant, the next cycle SHALL output tag 8'hF0|id with out_valid=1, and the FSM SHALL enter DATA.
REQ-021 req_ready[i] SHALL be combinational: state==DATA && grant_id==i && !pause; all other bits SHALL be 0.
REQ-022 A byte accepted (valid & ready) SHALL appear on out_data with out_valid=1 exactly one cycle later, giving a latency of 1.
REQ-023 In DATA, when the granted requester has req_valid=0 or pause=1, the next cycle SHALL output COMMA with out_valid=0 (bubble), and the FSM SHALL stay in DATA.
REQ-024 Acceptance with req_eop=1 SHALL return the FSM to IDLE and update last_grant.
REQ-025 A byte counter SHALL count accepted payload bytes per grant.
REQ-026 The MAX_PKT-th accepted byte without eop SHALL force a return to IDLE and pulse trunc for 1 cycle.
REQ-027 pause in IDLE SHALL block new grants.
REQ-028 pause SHALL NOT affect the SYNC count.
REQ-029 req_valid of non-granted requesters SHALL be ignored while in DATA.
REQ-030 A request arriving on the same cycle as eop acceptance SHALL NOT be granted until the next IDLE cycle, which leaves a 1-cycle COMMA gap between packets.
REQ-031 The round-robin pointer SHALL wrap from NREQ-1 to 0.

Reset
REQ-032 Asserting reset at any time SHALL immediately force: state=SYNC, out_data=COMMA, out_valid=0, grant_id=0, last_grant=NREQ-1, sync_done=0, trunc=0, counters=0.
REQ-033 A reset asserted mid-packet SHALL discard the packet, and the block SHALL re-run the full SYNC sequence after release.

Structure
REQ-034 COMMA, the tag prefix 4'hF, and the state encoding SHALL live in shared package ptos_pkg.
REQ-035 The round-robin selector SHALL be a sub-module rr_arbiter (inputs: request vector, last grant; outputs: one-hot grant, id).

Verification
REQ-036 Reset release with no requests -> 4 cycles COMMA/out_valid=0, then sync_done=1, COMMA continues.
REQ-037 Requester 2 sends AA,EE,EE,CC(eop) -> out: F2,AA,EE,EE,CC with out_valid=1, then COMMA.
REQ-038 All 4 requesters request continuously 1-byte packets, last_grant=3 -> tags F0,F1,F2,F3,F0 in order.
REQ-039 pause=1 for 2 cycles mid-packet -> 2 COMMA bubbles with out_valid=0, then data resumes, no byte lost or duplicated.
REQ-040 Requester 1 streams 20 bytes with no eop -> 16 bytes passed, trunc pulses, FSM returns to IDLE.
REQ-041 reset asserted during byte 3 -> out_valid=0 and COMMA immediately; after release, 4 SYNC commas occur before any grant.

Source files
------------

// File: rtl/ptos_pkg.sv
// Shared constants and state encoding for the PTOS lane arbiter.
package ptos_pkg;

  localparam logic [7:0] COMMA_SYM = 8'hBC;  // idle / alignment symbol
  localparam logic [3:0] TAG_PFX   = 4'hF;   // upper nibble of the grant tag byte

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage

// File: rtl/ptos_lane_arbiter_rr.sv
// Round-robin selector: picks the first active request after last_i, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o
);

  logic           found;
  logic [IDW-1:0] idx;

  // Scan last+1 .. last+NREQ (mod NREQ); the last grant has lowest priority.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_i) + k) % NREQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/ptos_lane_arbiter.sv
// Shares one byte lane into a parallel-to-serial converter among NREQ
// requesters: comma sync after reset, tagged round-robin packets, pause
// bubbles, and forced release after MAX_PKT bytes.
module ptos_lane_arbiter
  import ptos_pkg::*;
#(
  parameter  int         NREQ     = 4,
  parameter  int         SYNC_CNT = 4,
  parameter  int         MAX_PKT  = 16,
  parameter  logic [7:0] COMMA    = COMMA_SYM,
  localparam int         IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_eop,
  output logic [NREQ-1:0]   req_ready,
  input  logic              pause,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic [IDW-1:0]    grant_id,
  output logic              sync_done,
  output logic              trunc
);

  localparam int SCW = $clog2(SYNC_CNT + 1);
  localparam int BCW = $clog2(MAX_PKT + 1);

  state_e         state_q;
  logic [IDW-1:0] grant_q, last_q;
  logic [SCW-1:0] sync_cnt_q;
  logic [BCW-1:0] byte_cnt_q;
  logic [7:0]     out_data_q;
  logic           out_valid_q, sync_done_q, trunc_q;
  logic           gap_q;  // forces one comma cycle between packets

  logic [NREQ-1:0] rr_gnt;
  logic [IDW-1:0]  rr_id;
  logic [7:0]      cur_data;
  logic            cur_valid, cur_eop, accept;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (rr_gnt),
    .id_o   (rr_id)
  );

  // Select the owner's byte and raise ready only for the owner in DATA.
  always_comb begin
    cur_data  = '0;
    cur_valid = 1'b0;
    cur_eop   = 1'b0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) begin
        cur_data     = req_data[i*8 +: 8];
        cur_valid    = req_valid[i];
        cur_eop      = req_eop[i];
        req_ready[i] = (state_q == ST_DATA) && !pause;
      end
    end
  end

  assign accept = cur_valid && (state_q == ST_DATA) && !pause;

  // Lane FSM with registered outputs; every non-data cycle emits a comma.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SYNC;
      grant_q     <= '0;
      last_q      <= IDW'(NREQ - 1);
      sync_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      out_data_q  <= COMMA;
      out_valid_q <= 1'b0;
      sync_done_q <= 1'b0;
      trunc_q     <= 1'b0;
      gap_q       <= 1'b0;
    end else begin
      trunc_q     <= 1'b0;
      out_data_q  <= COMMA;
      out_valid_q <= 1'b0;
      case (state_q)
        ST_SYNC: begin
          if (sync_cnt_q == SCW'(SYNC_CNT - 1)) begin
            state_q     <= ST_IDLE;
            sync_done_q <= 1'b1;
            sync_cnt_q  <= '0;
          end else begin
            sync_cnt_q <= sync_cnt_q + 1'b1;
          end
        end
        ST_IDLE: begin
          gap_q <= 1'b0;
          if (!gap_q && (|rr_gnt) && !pause) begin
            grant_q     <= rr_id;
            byte_cnt_q  <= '0;
            out_data_q  <= {TAG_PFX, 4'(rr_id)};
            out_valid_q <= 1'b1;
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            out_data_q  <= cur_data;
            out_valid_q <= 1'b1;
            if (cur_eop || byte_cnt_q == BCW'(MAX_PKT - 1)) begin
              state_q    <= ST_IDLE;
              last_q     <= grant_q;
              gap_q      <= 1'b1;
              byte_cnt_q <= '0;
              trunc_q    <= !cur_eop;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_SYNC;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant_id  = grant_q;
  assign sync_done = sync_done_q;
  assign trunc     = trunc_q;

endmodule

// File: tb/tb_ptos_lane_arbiter.sv
// Directed bench for ptos_lane_arbiter: sync, tagging, round robin, pause,
// truncation and mid-packet reset.
module tb_ptos_lane_arbiter;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_eop = '0;
  logic [NREQ-1:0]   req_ready;
  logic              pause = 1'b0;
  logic [7:0]        out_data;
  logic              out_valid;
  logic [1:0]        grant_id;
  logic              sync_done;
  logic              trunc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ptos_lane_arbiter #(.NREQ(NREQ), .SYNC_CNT(4), .MAX_PKT(16), .COMMA(8'hBC)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_eop   (req_eop),
    .req_ready (req_ready),
    .pause     (pause),
    .out_data  (out_data),
    .out_valid (out_valid),
    .grant_id  (grant_id),
    .sync_done (sync_done),
    .trunc     (trunc)
  );

  task automatic clr_req();
    req_data  = '0;
    req_valid = '0;
    req_eop   = '0;
  endtask

  task automatic drive(input int id, input logic v, input logic [7:0] d, input logic e);
    clr_req();
    req_valid[id]       = v;
    req_data[id*8 +: 8] = d;
    req_eop[id]         = e;
  endtask

  // Reset, then let the four sync cycles elapse so the FSM sits in IDLE.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pause = 1'b0;
    clr_req();
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pause = 1'b0;
    clr_req();
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_data, grant_id, sync_done, trunc, req_ready} !==
        {1'b0, 8'hBC, 2'd0, 1'b0, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%h g=%0d s=%b t=%b r=%b exp v=0 d=bc g=0 s=0 t=0 r=0000",
               out_valid, out_data, grant_id, sync_done, trunc, req_ready);
    end
    // pause held through sync must not stretch the sequence
    pause = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, sync_done} !== {1'b0, 8'hBC, (i >= 3)}) begin
        failures++;
        $display("FAIL sync_cycle%0d got v=%b d=%h s=%b exp v=0 d=bc s=%b",
                 i, out_valid, out_data, sync_done, (i >= 3));
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_single_packet();
    logic [7:0] din [6] = '{8'hAA, 8'hAA, 8'hEE, 8'hEE, 8'hCC, 8'h00};
    logic       vin [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ein [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exd [6] = '{8'hF2, 8'hAA, 8'hEE, 8'hEE, 8'hCC, 8'hBC};
    logic       exv [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    drive(2, vin[0], din[0], ein[0]);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data} !== {exv[n], exd[n]}) begin
        failures++;
        $display("FAIL single_pkt_c%0d got v=%b d=%h exp v=%b d=%h",
                 n, out_valid, out_data, exv[n], exd[n]);
      end
      if (n == 0) begin
        checks++;
        if ({grant_id, req_ready} !== {2'd2, 4'b0100}) begin
          failures++;
          $display("FAIL single_pkt_grant got g=%0d r=%b exp g=2 r=0100", grant_id, req_ready);
        end
      end
      if (n < 5) drive(2, vin[n+1], din[n+1], ein[n+1]);
    end
    clr_req();
  endtask

  task automatic test_round_robin();
    logic [7:0] ed;
    logic       ev;
    logic [3:0] er;
    int         id;
    do_reset();
    req_valid = 4'hF;
    req_eop   = 4'hF;
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    // tag, data, inter-packet comma gap per owner; wraps 3 -> 0
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      id = (n / 3) % 4;
      case (n % 3)
        0:       begin ed = 8'hF0 | 8'(id); ev = 1'b1; er = 4'(1 << id); end
        1:       begin ed = 8'h10 + 8'(id); ev = 1'b1; er = 4'b0000;     end
        default: begin ed = 8'hBC;          ev = 1'b0; er = 4'b0000;     end
      endcase
      checks++;
      if ({out_valid, out_data, req_ready} !== {ev, ed, er}) begin
        failures++;
        $display("FAIL rr_c%0d got v=%b d=%h r=%b exp v=%b d=%h r=%b",
                 n, out_valid, out_data, req_ready, ev, ed, er);
      end
    end
    clr_req();
  endtask

  task automatic test_pause();
    logic [7:0] din [9] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h00};
    logic       vin [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ein [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       pin [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] exd [9] = '{8'hBC, 8'hBC, 8'hF1, 8'h11, 8'hBC, 8'hBC, 8'h22, 8'h33, 8'hBC};
    logic       exv [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    drive(1, vin[0], din[0], ein[0]);
    pause = pin[0];
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data} !== {exv[n], exd[n]}) begin
        failures++;
        $display("FAIL pause_c%0d got v=%b d=%h exp v=%b d=%h",
                 n, out_valid, out_data, exv[n], exd[n]);
      end
      if (n == 1) begin
        checks++;
        if ({grant_id, req_ready} !== {2'd0, 4'b0000}) begin
          failures++;
          $display("FAIL pause_idle_block got g=%0d r=%b exp g=0 r=0000", grant_id, req_ready);
        end
      end
      if (n < 8) begin
        drive(1, vin[n+1], din[n+1], ein[n+1]);
        pause = pin[n+1];
      end
    end
    clr_req();
    pause = 1'b0;
  endtask

  task automatic test_trunc();
    logic [7:0] ed;
    logic       ev;
    do_reset();
    drive(1, 1'b1, 8'h40, 1'b0);
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (n == 0 || n == 18)      begin ed = 8'hF1;           ev = 1'b1; end
      else if (n <= 16)           begin ed = 8'h40 + 8'(n-1); ev = 1'b1; end
      else if (n >= 19 && n < 23) begin ed = 8'h50 + 8'(n-19); ev = 1'b1; end
      else                        begin ed = 8'hBC;           ev = 1'b0; end
      checks++;
      if ({out_valid, out_data, trunc} !== {ev, ed, (n == 16)}) begin
        failures++;
        $display("FAIL trunc_c%0d got v=%b d=%h t=%b exp v=%b d=%h t=%b",
                 n, out_valid, out_data, trunc, ev, ed, (n == 16));
      end
      if (n == 16) begin
        checks++;
        if (req_ready !== 4'b0000) begin
          failures++;
          $display("FAIL trunc_release got r=%b exp r=0000", req_ready);
        end
      end
      if (n < 16)       drive(1, 1'b1, 8'h40 + 8'(n), 1'b0);
      else if (n < 18)  drive(1, 1'b1, 8'h50, 1'b0);
      else if (n < 22)  drive(1, 1'b1, 8'h50 + 8'(n-18), 1'b0);
      else              clr_req();
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] din [4] = '{8'hA1, 8'hA1, 8'hA2, 8'hA3};
    logic [7:0] exd [4] = '{8'hF3, 8'hA1, 8'hA2, 8'hA3};
    do_reset();
    drive(3, 1'b1, din[0], 1'b0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data} !== {1'b1, exd[n]}) begin
        failures++;
        $display("FAIL midrst_pre_c%0d got v=%b d=%h exp v=1 d=%h", n, out_valid, out_data, exd[n]);
      end
      if (n < 3) drive(3, 1'b1, din[n+1], 1'b0);
    end
    drive(3, 1'b1, 8'hA4, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, sync_done, grant_id, trunc} !== {1'b0, 8'hBC, 1'b0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_async got v=%b d=%h s=%b g=%0d t=%b exp v=0 d=bc s=0 g=0 t=0",
               out_valid, out_data, sync_done, grant_id, trunc);
    end
    drive(3, 1'b1, 8'hA1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_data, sync_done, req_ready} !== {1'b0, 8'hBC, (i == 3), 4'b0000}) begin
        failures++;
        $display("FAIL midrst_sync_c%0d got v=%b d=%h s=%b r=%b exp v=0 d=bc s=%b r=0000",
                 i, out_valid, out_data, sync_done, req_ready, (i == 3));
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_data, grant_id} !== {1'b1, 8'hF3, 2'd3}) begin
      failures++;
      $display("FAIL midrst_regrant got v=%b d=%h g=%0d exp v=1 d=f3 g=3", out_valid, out_data, grant_id);
    end
    clr_req();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_pause();
    test_trunc();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
